// File: rtl/seg_dma_wr_addr_gen.sv
// seg_dma_wr_addr_gen: DMA write address generator.
// Stripes cache-line write requests round-robin over four segment bases,
// counts write completions and raises a sticky done once every line is acked.
module seg_dma_wr_addr_gen #(
   parameter int ADDR_WIDTH = 64,
   parameter int SIZE_WIDTH = 17,
   parameter int LINE_BYTES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic [SIZE_WIDTH-1:0] size,
   input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
   input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
   input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
   input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
   output logic                  req_valid,
   output logic [ADDR_WIDTH-1:0] req_addr,
   output logic [1:0]            req_seg,
   input  logic                  req_ready,
   input  logic                  wr_ack,
   output logic                  busy,
   output logic                  done
);

   localparam int LB_SHIFT = $clog2(LINE_BYTES);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [ADDR_WIDTH-1:0] base0_q, base0_d, base1_q, base1_d;
   logic [ADDR_WIDTH-1:0] base2_q, base2_d, base3_q, base3_d;
   logic [SIZE_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
   logic [SIZE_WIDTH-1:0] ack_cnt_q, ack_cnt_d;
   logic                  req_valid_q, req_valid_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [1:0]            req_seg_q, req_seg_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  zero_pend_q, zero_pend_d;

   logic [SIZE_WIDTH-1:0] next_k;
   logic [SIZE_WIDTH:0]   ack_sum;
   logic                  xfer;

   // Byte address of line k: segment base plus one cache line per full stripe row.
   function automatic logic [ADDR_WIDTH-1:0] line_addr(
      input logic [ADDR_WIDTH-1:0] b0,
      input logic [ADDR_WIDTH-1:0] b1,
      input logic [ADDR_WIDTH-1:0] b2,
      input logic [ADDR_WIDTH-1:0] b3,
      input logic [SIZE_WIDTH-1:0] k
   );
      logic [ADDR_WIDTH-1:0] base;
      logic [ADDR_WIDTH-1:0] row;
      case (k[1:0])
         2'd0:    base = b0;
         2'd1:    base = b1;
         2'd2:    base = b2;
         default: base = b3;
      endcase
      row = ADDR_WIDTH'(k >> 2);
      return base + (row << LB_SHIFT);
   endfunction

   // Next-state and next-output logic for the IDLE/ISSUE/DRAIN controller.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      base0_d     = base0_q;
      base1_d     = base1_q;
      base2_d     = base2_q;
      base3_d     = base3_q;
      issue_cnt_d = issue_cnt_q;
      ack_cnt_d   = ack_cnt_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_seg_d   = req_seg_q;
      busy_d      = busy_q;
      done_d      = done_q;
      zero_pend_d = 1'b0;

      next_k  = issue_cnt_q + SIZE_WIDTH'(1);
      ack_sum = {1'b0, ack_cnt_q} + {{SIZE_WIDTH{1'b0}}, wr_ack};
      xfer    = req_valid_q && req_ready;

      case (state_q)
         IDLE: begin
            // A zero-length go reports done one cycle after clearing it.
            if (zero_pend_q) done_d = 1'b1;
            if (go) begin
               done_d = 1'b0;
               if (size != '0) begin
                  size_d      = size;
                  base0_d     = wr_addr_s0;
                  base1_d     = wr_addr_s1;
                  base2_d     = wr_addr_s2;
                  base3_d     = wr_addr_s3;
                  issue_cnt_d = '0;
                  ack_cnt_d   = '0;
                  busy_d      = 1'b1;
                  req_valid_d = 1'b1;
                  req_addr_d  = wr_addr_s0;
                  req_seg_d   = 2'd0;
                  state_d     = ISSUE;
               end else begin
                  zero_pend_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            ack_cnt_d = ack_sum[SIZE_WIDTH-1:0];
            if (xfer) begin
               if (issue_cnt_q == size_q - SIZE_WIDTH'(1)) begin
                  req_valid_d = 1'b0;
                  state_d     = DRAIN;
               end else begin
                  issue_cnt_d = next_k;
                  req_addr_d  = line_addr(base0_q, base1_q, base2_q, base3_q, next_k);
                  req_seg_d   = next_k[1:0];
               end
            end
         end
         DRAIN: begin
            ack_cnt_d = ack_sum[SIZE_WIDTH-1:0];
            if (ack_sum == {1'b0, size_q}) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; asynchronous reset leaves no residual transfer state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         size_q      <= '0;
         base0_q     <= '0;
         base1_q     <= '0;
         base2_q     <= '0;
         base3_q     <= '0;
         issue_cnt_q <= '0;
         ack_cnt_q   <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_seg_q   <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         zero_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         base0_q     <= base0_d;
         base1_q     <= base1_d;
         base2_q     <= base2_d;
         base3_q     <= base3_d;
         issue_cnt_q <= issue_cnt_d;
         ack_cnt_q   <= ack_cnt_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_seg_q   <= req_seg_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         zero_pend_q <= zero_pend_d;
      end
   end

   assign req_valid = req_valid_q;
   assign req_addr  = req_addr_q;
   assign req_seg   = req_seg_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
